// File: rtl/reg_view_debugger.sv
// Front-panel debug unit: debounced buttons select a register window, one regfile read port is time-shared for two views plus PC.
// Latency: raw press to selection change 2+DEBOUNCE_CYC cycles; new selection reaches both views within 2 further cycles.
// Optional halt/single-step control is enabled by defining DBG_STEP_EN; without it cpu_run is tied high and btn3 clears sel.
module reg_view_debugger #(
  parameter int DATA_WIDTH   = 32,
  parameter int NUM_REGS     = 32,
  parameter int PC_WIDTH     = 12,
  parameter int DEBOUNCE_CYC = 16,
  parameter int NUM_BTN      = 4,
  localparam int SELW        = $clog2(NUM_REGS)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [NUM_BTN-1:0]    btn_raw,
  input  logic [PC_WIDTH-1:0]   pc,
  output logic [SELW-1:0]       dbg_raddr,
  input  logic [DATA_WIDTH-1:0] dbg_rdata,
  output logic [DATA_WIDTH-1:0] view_a,
  output logic [DATA_WIDTH-1:0] view_b,
  output logic [PC_WIDTH-1:0]   view_pc,
  output logic [SELW-1:0]       view_sel,
  output logic                  frozen,
  output logic                  cpu_run
);

  localparam int CNTW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam logic [CNTW-1:0] CNT_LAST = CNTW'(DEBOUNCE_CYC - 1);
  localparam logic [SELW-1:0] SEL_LAST = SELW'(NUM_REGS - 1);

  // Button input path state
  logic [NUM_BTN-1:0] sync1_q, sync2_q;
  logic [NUM_BTN-1:0] acc_q, acc_d;
  logic [CNTW-1:0]    cnt_q [NUM_BTN];
  logic [CNTW-1:0]    cnt_d [NUM_BTN];
  logic [3:0]         btn_p;

  // Selection / view state
  logic [SELW-1:0]       sel_q, sel_d, sel_inc, sel_dec;
  logic                  phase_q;
  logic                  frozen_q, frozen_d;
  logic [DATA_WIDTH-1:0] view_a_q, view_b_q;
  logic [PC_WIDTH-1:0]   view_pc_q;
  logic                  freeze_tgl;
  logic                  sel_clr;

  // Debounce next-state: a level is accepted only after DEBOUNCE_CYC disagreeing cycles in a row
  always_comb begin
    acc_d = acc_q;
    for (int i = 0; i < NUM_BTN; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != acc_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          acc_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNTW'(1);
        end
      end
    end
  end

  // Pulse fires in the cycle whose edge flips the accepted level 0->1
  assign btn_p = acc_d[3:0] & ~acc_q[3:0];

  // Synchroniser and debouncer registers for every button
  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      acc_q   <= '0;
      for (int i = 0; i < NUM_BTN; i++) cnt_q[i] <= '0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
      acc_q   <= acc_d;
      for (int i = 0; i < NUM_BTN; i++) cnt_q[i] <= cnt_d[i];
    end
  end

`ifdef DBG_STEP_EN
  logic halted_q, step_q;

  // Halt toggles on btn3; btn2 while halted issues a one-clock run strobe
  always_ff @(posedge clock) begin
    if (reset) begin
      halted_q <= 1'b0;
      step_q   <= 1'b0;
    end else begin
      halted_q <= halted_q ^ btn_p[3];
      step_q   <= btn_p[2] & halted_q;
    end
  end

  assign freeze_tgl = btn_p[2] & ~halted_q;
  assign sel_clr    = 1'b0;
  assign cpu_run    = ~halted_q | step_q;
`else
  assign freeze_tgl = btn_p[2];
  assign sel_clr    = btn_p[3];
  assign cpu_run    = 1'b1;
`endif

  assign sel_inc = (sel_q == SEL_LAST) ? '0 : sel_q + SELW'(1);
  assign sel_dec = (sel_q == '0) ? SEL_LAST : sel_q - SELW'(1);

  // Selection next-state: clear wins, opposing up/down presses cancel
  always_comb begin
    sel_d = sel_q;
    if (sel_clr) begin
      sel_d = '0;
    end else if (btn_p[0] && !btn_p[1]) begin
      sel_d = sel_inc;
    end else if (btn_p[1] && !btn_p[0]) begin
      sel_d = sel_dec;
    end
  end

  assign frozen_d = frozen_q ^ freeze_tgl;

  // Even phase reads sel into view_a, odd phase reads sel+1 into view_b
  assign dbg_raddr = phase_q ? sel_inc : sel_q;

  // View capture uses the pre-edge frozen value so the freezing edge still captures
  always_ff @(posedge clock) begin
    if (reset) begin
      sel_q     <= '0;
      phase_q   <= 1'b0;
      frozen_q  <= 1'b0;
      view_a_q  <= '0;
      view_b_q  <= '0;
      view_pc_q <= '0;
    end else begin
      sel_q    <= sel_d;
      phase_q  <= ~phase_q;
      frozen_q <= frozen_d;
      if (!frozen_q) begin
        view_pc_q <= pc;
        if (!phase_q) view_a_q <= dbg_rdata;
        else          view_b_q <= dbg_rdata;
      end
    end
  end

  assign view_a   = view_a_q;
  assign view_b   = view_b_q;
  assign view_pc  = view_pc_q;
  assign view_sel = sel_q;
  assign frozen   = frozen_q;

endmodule

// File: tb/tb_reg_view_debugger.sv
// Directed bench for reg_view_debugger with a behavioural regfile (rN = 0x100+N).
// Expected selections are queued when a press is driven and popped once the press has settled.
module tb_reg_view_debugger;

  localparam int DW = 32;
  localparam int NR = 32;
  localparam int PW = 12;
  localparam int DB = 4;
  localparam int NB = 4;
  localparam int LAT = 2 + DB;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [NB-1:0] btn_raw = '0;
  logic [PW-1:0] pc = '0;
  logic [4:0]    dbg_raddr;
  logic [DW-1:0] dbg_rdata;
  logic [DW-1:0] view_a, view_b;
  logic [PW-1:0] view_pc;
  logic [4:0]    view_sel;
  logic          frozen, cpu_run;

  logic [DW-1:0] regs [NR];
  int            sb_q [$];
  int            checks = 0;
  int            errors = 0;

  assign dbg_rdata = regs[dbg_raddr];

  reg_view_debugger #(
    .DATA_WIDTH(DW), .NUM_REGS(NR), .PC_WIDTH(PW), .DEBOUNCE_CYC(DB), .NUM_BTN(NB)
  ) dut (
    .clock(clock), .reset(reset), .btn_raw(btn_raw), .pc(pc),
    .dbg_raddr(dbg_raddr), .dbg_rdata(dbg_rdata),
    .view_a(view_a), .view_b(view_b), .view_pc(view_pc), .view_sel(view_sel),
    .frozen(frozen), .cpu_run(cpu_run)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Hold mask for 8 cycles, release for 8, then compare selection, press latency and views
  task automatic press(input logic [NB-1:0] mask, input int exp_sel, input bit chk_lat, input bit chk_view);
    int         lat;
    int         e;
    logic [4:0] prev;
    prev = view_sel;
    lat  = 0;
    sb_q.push_back(exp_sel);
    btn_raw = mask;
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (lat == 0 && view_sel != prev) lat = i;
    end
    btn_raw = '0;
    for (int i = 0; i < 8; i++) tick();
    e = sb_q.pop_front();
    check("sel", 32'(view_sel), 32'(e));
    if (chk_lat) check("press_latency", 32'(lat), 32'(LAT));
    if (chk_view) begin
      check("view_a", view_a, regs[e]);
      check("view_b", view_b, regs[(e + 1) % NR]);
    end
  endtask

  initial begin
    int run_cnt;
    for (int i = 0; i < NR; i++) regs[i] = 32'h100 + 32'(i);

    // Reset state
    reset = 1'b1;
    pc    = 12'h5A5;
    tick();
    tick();
    check("rst_sel", 32'(view_sel), 32'd0);
    check("rst_view_a", view_a, 32'd0);
    check("rst_view_b", view_b, 32'd0);
    check("rst_view_pc", 32'(view_pc), 32'd0);
    check("rst_frozen", 32'(frozen), 32'd0);
    check("rst_cpu_run", 32'(cpu_run), 32'd1);
    reset = 1'b0;

    // Idle: views track r0/r1 and PC
    for (int i = 0; i < 10; i++) tick();
    check("idle_sel", 32'(view_sel), 32'd0);
    check("idle_view_a", view_a, 32'h100);
    check("idle_view_b", view_b, 32'h101);
    check("idle_view_pc", 32'(view_pc), 32'h5A5);
    check("idle_frozen", 32'(frozen), 32'd0);
    check("idle_cpu_run", 32'(cpu_run), 32'd1);

    // Two-cycle glitch is rejected
    btn_raw = 4'b0001;
    tick();
    tick();
    btn_raw = '0;
    for (int i = 0; i < 10; i++) tick();
    check("glitch_sel", 32'(view_sel), 32'd0);

    // Up, down, wrap down, simultaneous up+down
    press(4'b0001, 1, 1'b1, 1'b1);
    press(4'b0010, 0, 1'b1, 1'b1);
    press(4'b0010, 31, 1'b1, 1'b1);
    press(4'b0011, 31, 1'b0, 1'b1);
`ifndef DBG_STEP_EN
    press(4'b1000, 0, 1'b1, 1'b1);
`else
    press(4'b0001, 0, 1'b1, 1'b1);
`endif

    // Move to r3 and freeze
    press(4'b0001, 1, 1'b1, 1'b0);
    press(4'b0001, 2, 1'b1, 1'b0);
    press(4'b0001, 3, 1'b1, 1'b1);
    press(4'b0100, 3, 1'b0, 1'b0);
    check("frz_frozen", 32'(frozen), 32'd1);
    regs[3] = 32'hDEAD;
    pc      = 12'h123;
    for (int i = 0; i < 4; i++) tick();
    check("frz_view_a_hold", view_a, 32'h103);
    check("frz_view_pc_hold", 32'(view_pc), 32'h5A5);
    press(4'b0001, 4, 1'b1, 1'b0);
    check("frz_sel_moves_view_a", view_a, 32'h103);
    check("frz_sel_moves_view_b", view_b, 32'h104);
    press(4'b0010, 3, 1'b1, 1'b0);

    // Unfreeze: new r3 contents and PC appear
    press(4'b0100, 3, 1'b0, 1'b1);
    check("unfrz_frozen", 32'(frozen), 32'd0);
    check("unfrz_view_pc", 32'(view_pc), 32'h123);

    // Freeze again, then reset mid-debounce
    press(4'b0100, 3, 1'b0, 1'b0);
    btn_raw = 4'b0001;
    for (int i = 0; i < 4; i++) tick();
    reset = 1'b1;
    tick();
    check("mid_rst_sel", 32'(view_sel), 32'd0);
    check("mid_rst_view_a", view_a, 32'd0);
    check("mid_rst_view_b", view_b, 32'd0);
    check("mid_rst_view_pc", 32'(view_pc), 32'd0);
    check("mid_rst_frozen", 32'(frozen), 32'd0);
    check("mid_rst_cpu_run", 32'(cpu_run), 32'd1);
    reset = 1'b0;
    press(4'b0001, 1, 1'b1, 1'b1);

`ifdef DBG_STEP_EN
    // Halt, single step, resume
    press(4'b1000, 1, 1'b0, 1'b0);
    check("halt_cpu_run", 32'(cpu_run), 32'd0);
    check("halt_frozen", 32'(frozen), 32'd0);
    run_cnt = 0;
    btn_raw = 4'b0100;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (cpu_run) run_cnt++;
    end
    btn_raw = '0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (cpu_run) run_cnt++;
    end
    check("step_run_cycles", 32'(run_cnt), 32'd1);
    check("step_frozen", 32'(frozen), 32'd0);
    press(4'b1000, 1, 1'b0, 1'b0);
    check("resume_cpu_run", 32'(cpu_run), 32'd1);
`else
    run_cnt = 0;
    check("cpu_run_tied", 32'(cpu_run) + 32'(run_cnt), 32'd1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
